// File: rtl/drum_memory.sv
// drum_memory: rotating-drum word store; each access waits for its sector to come under the head.
// Sector and sub-slot counters model the drum angle and run freely in every state.
module drum_memory #(
   parameter int SECTOR_BITS   = 5,
   parameter int SECTOR_CYCLES = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [11:0] addr,
   input  logic [30:0] write_data,
   output logic [30:0] read_data,
   output logic        finish,
   output logic        busy
);
   localparam int SUB_W = (SECTOR_CYCLES > 1) ? $clog2(SECTOR_CYCLES) : 1;
   localparam logic [SUB_W-1:0] LAST = SUB_W'(SECTOR_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state, state_n;
   logic [SUB_W-1:0] sub;
   logic [SECTOR_BITS-1:0] sec;
   logic [11:0] addr_q;
   logic [30:0] data_q;
   logic wr_q, accept, xfer;
   logic [30:0] mem [0:4095];
   assign accept = (state == IDLE) && (read_enable || write_enable);
   assign xfer = (state == WAIT) && (sub == '0) && (sec == addr_q[SECTOR_BITS-1:0]);
   always_comb begin
      state_n = state;
      state_n = accept ? WAIT : xfer ? DONE : (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         sub       <= '0;
         sec       <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
         read_data <= '0;
         finish    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state <= state_n;
         sub   <= (sub == LAST) ? '0 : sub + 1'b1;
         if (sub == LAST) sec <= sec + 1'b1;
         if (accept) begin
            addr_q <= addr;
            data_q <= write_data;
            wr_q   <= write_enable;
         end
         if (xfer && !wr_q) read_data <= mem[addr_q];
         finish <= (state_n == DONE);
         busy   <= (state_n != IDLE);
      end
   end
   // Array has no reset so it maps onto RAM; an abandoned write never reaches it.
   always_ff @(posedge clk) begin
      if (xfer && wr_q) mem[addr_q] <= data_q;
   end
endmodule

// File: tb/tb_drum_memory.sv
// tb_drum_memory: directed vectors timed against the drum angle, plus busy-drop and reset-abort sequences.
module tb_drum_memory;
   localparam int REV = 128;
   logic clk = 1'b0;
   logic resetn, read_enable, write_enable, finish, busy;
   logic [11:0] addr;
   logic [30:0] write_data, read_data;
   int n_cmp = 0;
   int n_bad = 0;
   int unsigned pos;
   typedef struct {
      logic we;
      logic re;
      logic [11:0] a;
      logic [30:0] d;
      int start;
      int lat;
      logic [30:0] rd;
   } vec_t;
   vec_t vecs [11];
   drum_memory dut (
      .clk(clk), .resetn(resetn), .read_enable(read_enable), .write_enable(write_enable),
      .addr(addr), .write_data(write_data), .read_data(read_data), .finish(finish), .busy(busy)
   );
   always #5 clk = ~clk;
   // pos = drum angle index (sector*4 + sub-slot) seen just before the next rising edge
   always @(posedge clk or negedge resetn) begin
      if (!resetn) pos <= 0;
      else pos <= pos + 1;
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wait_pos(input int start);
      int n = 0;
      while ((pos % REV) != start && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic pulse(input logic we, input logic re, input logic [11:0] a, input logic [30:0] d);
      write_enable = we;
      read_enable = re;
      addr = a;
      write_data = d;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      read_enable = 1'b0;
   endtask
   task automatic do_req(input logic we, input logic re, input logic [11:0] a, input logic [30:0] d,
                         input int start, output int lat, output logic b1, output logic [30:0] rd,
                         output logic fin2, output logic busy2);
      wait_pos(start);
      pulse(we, re, a, d);
      @(negedge clk);
      b1 = busy;
      lat = 0;
      while (!finish && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      rd = read_data;
      @(negedge clk);
      fin2 = finish;
      busy2 = busy;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int lat, fins, req_pos, fin_pos;
      logic b1, fin2, busy2;
      logic [30:0] rd;
      vecs[0]  = '{1'b1, 1'b0, 12'h005, 31'h1234_5678, 0,   20,  31'h0000_0000};
      vecs[1]  = '{1'b0, 1'b1, 12'h005, 31'h0000_0000, 10,  10,  31'h1234_5678};
      vecs[2]  = '{1'b1, 1'b0, 12'h025, 31'h0ABC_DEF0, 100, 48,  31'h1234_5678};
      vecs[3]  = '{1'b0, 1'b1, 12'h025, 31'h0000_0000, 20,  128, 31'h0ABC_DEF0};
      vecs[4]  = '{1'b1, 1'b1, 12'h003, 31'h7FFF_FFFF, 11,  1,   31'h0ABC_DEF0};
      vecs[5]  = '{1'b0, 1'b1, 12'h003, 31'h0000_0000, 0,   12,  31'h7FFF_FFFF};
      vecs[6]  = '{1'b1, 1'b0, 12'h010, 31'h5555_AAAA, 60,  4,   31'h7FFF_FFFF};
      vecs[7]  = '{1'b1, 1'b0, 12'h00A, 31'h1111_2222, 0,   40,  31'h7FFF_FFFF};
      vecs[8]  = '{1'b1, 1'b0, 12'h7FF, 31'h4000_0001, 125, 127, 31'h7FFF_FFFF};
      vecs[9]  = '{1'b0, 1'b1, 12'h7FF, 31'h0000_0000, 123, 1,   31'h4000_0001};
      vecs[10] = '{1'b0, 1'b1, 12'h010, 31'h0000_0000, 63,  1,   31'h5555_AAAA};
      resetn = 1'b0;
      read_enable = 1'b0;
      write_enable = 1'b0;
      addr = '0;
      write_data = '0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset finish", finish, 0);
      check("reset read_data", read_data, 0);
      resetn = 1'b1;
      for (int i = 0; i < 11; i++) begin
         do_req(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d, vecs[i].start, lat, b1, rd, fin2, busy2);
         check($sformatf("v%0d busy_after_req", i), b1, 1);
         check($sformatf("v%0d latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d read_data", i), rd, vecs[i].rd);
         check($sformatf("v%0d finish_one_cycle", i), fin2, 0);
         check($sformatf("v%0d busy_cleared", i), busy2, 0);
      end
      repeat (10) @(negedge clk);
      check("read_data held idle", read_data, 31'h5555_AAAA);
      wait_pos(0);
      req_pos = pos;
      pulse(1'b1, 1'b0, 12'h008, 31'h2468_ACE0);
      repeat (5) @(negedge clk);
      pulse(1'b1, 1'b0, 12'h010, 31'h7777_7777);
      fins = 0;
      fin_pos = -1;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         if (finish) begin
            fins++;
            if (fin_pos < 0) fin_pos = pos;
         end
      end
      check("busy-drop finish count", fins, 1);
      check("busy-drop latency", fin_pos - 1 - req_pos, 32);
      do_req(1'b0, 1'b1, 12'h008, '0, 0, lat, b1, rd, fin2, busy2);
      check("busy-drop read 008", rd, 31'h2468_ACE0);
      do_req(1'b0, 1'b1, 12'h010, '0, 63, lat, b1, rd, fin2, busy2);
      check("busy-drop read 010", rd, 31'h5555_AAAA);
      wait_pos(0);
      pulse(1'b1, 1'b0, 12'h00A, 31'h3333_4444);
      repeat (10) @(negedge clk);
      check("abort busy before reset", busy, 1);
      resetn = 1'b0;
      #1;
      check("abort busy async", busy, 0);
      check("abort finish async", finish, 0);
      check("abort read_data async", read_data, 0);
      @(negedge clk);
      resetn = 1'b1;
      fins = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (finish) fins++;
      end
      check("abort no finish", fins, 0);
      do_req(1'b0, 1'b1, 12'h00A, '0, 0, lat, b1, rd, fin2, busy2);
      check("abort read latency", lat, 40);
      check("abort read 00A", rd, 31'h1111_2222);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/drum_memory.md
DRUM_MEMORY -- requirements
Module: drum_memory

Interface
REQ-001 Parameter: SECTOR_BITS, default 5, log2 of words per drum track (angular slots per revolution).
REQ-002 Parameter: SECTOR_CYCLES, default 4, clocks per angular slot (range 2..16).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-005 Port: read_enable  input  1  one-cycle read request pulse from pulse unit.
REQ-006 Port: write_enable  input  1  one-cycle write request pulse from pulse unit.
REQ-007 Port: addr  input  12  word address; addr[SECTOR_BITS-1:0] = angular sector, upper bits = track.
REQ-008 Port: write_data  input  31  word to store, bit 30 = sign.
REQ-009 Port: read_data  output  31  last word read, registered, held until next read completes.
REQ-010 Port: finish  output  1  one-cycle completion pulse (mem_reply to pulse unit).
REQ-011 Port: busy  output  1  high while a request is outstanding.

Function
REQ-012 Storage: 4096 x 31-bit array; contents not affected by reset.
REQ-013 Rotation position: sub-slot counter 0..SECTOR_CYCLES-1 and sector counter 0..2^SECTOR_BITS-1, free-running every cycle in all states; sector increments when sub-slot wraps to 0; sector wraps modulo 2^SECTOR_BITS.
REQ-014 States: IDLE, WAIT, DONE.
REQ-015 IDLE: on edge with read_enable or write_enable high -> latch addr, write_data, op into internal registers; go WAIT.
REQ-016 Both enables high in same cycle: accepted as write; read_data unchanged.
REQ-017 WAIT: on edge where position == (latched sector, sub-slot 0) -> transfer (write: array[addr] <= data; read: read_data <= array[addr]); go DONE.
REQ-018 DONE: finish = 1 for exactly this one cycle; next edge -> IDLE.
REQ-019 busy = 1 in WAIT and DONE; 0 in IDLE.
REQ-020 Requests arriving in WAIT or DONE ignored; latched address/data/op unchanged.
REQ-021 Request sampled on the edge whose pre-edge position equals its target slot misses it; waits one full revolution.
REQ-022 Latency (request edge to finish-high cycle): 1 to 2^SECTOR_BITS*SECTOR_CYCLES edges; exactly 128 worst case at defaults.
REQ-023 finish, busy, read_data are registered outputs; no combinational path from inputs.
REQ-024 Write data becomes readable by any request accepted after finish.

Reset
REQ-025 resetn low: state IDLE, finish 0, busy 0, read_data 0, sub-slot 0, sector 0, latched regs 0, immediately (asynchronous).
REQ-026 Reset during WAIT/DONE abandons request: no array write occurs, no finish pulse after release.
REQ-027 After release, rotation counters restart from (0,0) on first edge.

Verification
REQ-028 Reset release, then write_enable at edge with pre-edge position (0,0), addr 0x005, data 0x1234_5678 -> busy high next cycle; transfer at position (5,0), 20 edges after request; finish high one cycle; busy low after.
REQ-029 Then read_enable addr 0x005 -> finish pulse once; read_data = 0x1234_5678 from that cycle on, held through later idle cycles.
REQ-030 Read addr 0x025 (sector 5) sampled at pre-edge position (5,0) -> finish high exactly 128 edges later (full revolution).
REQ-031 read_enable and write_enable together, addr 0x003, data 0x7FFF_FFFF -> write performed, read_data unchanged; subsequent read of 0x003 returns 0x7FFF_FFFF.
REQ-032 Second write pulse to addr 0x010 while busy for write to 0x008 -> only 0x008 written, one finish; 0x010 retains old value.
REQ-033 resetn low mid-WAIT of a write to 0x00A -> busy/finish 0 immediately, no finish after release, 0x00A retains old value.
